// File: rtl/mips_ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one registered ROM
// request per cycle and buffers {pc, word} pairs in a first-word-fall-through queue.
module mips_ifetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter int                    PC_STEP    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    rom_enable,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_data,
  output logic                    inst_valid,
  output logic [DATA_WIDTH-1:0]   inst_data,
  output logic [ADDR_WIDTH-1:0]   inst_pc,
  input  logic                    inst_ready,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_pc   [DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_rom_enable;
  logic [ADDR_WIDTH-1:0] r_rom_addr;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic [CW-1:0]         w_count_next;
  logic                  w_en_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  // Redirect overrides push and pop; the word returned alongside it is dropped.
  always_comb begin
    w_valid      = (r_count != '0);
    w_push       = r_rom_enable & ~redirect;
    w_pop        = w_valid & inst_ready & ~redirect;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    w_addr_next  = r_rom_addr;
    if (redirect) begin
      w_count_next = '0;
      w_addr_next  = redirect_pc;
    end else if (r_rom_enable) begin
      w_addr_next  = r_rom_addr + ADDR_WIDTH'(PC_STEP);
    end
    // Only request when the returning word is guaranteed a free slot.
    w_en_next = redirect | (w_count_next < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_enable <= 1'b0;
      r_rom_addr   <= RESET_PC;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
    end else begin
      r_rom_enable <= w_en_next;
      r_rom_addr   <= w_addr_next;
      r_count      <= w_count_next;
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= rom_data;
      r_mem_pc[r_wr_ptr]   <= r_rom_addr;
    end
  end

  assign rom_enable = r_rom_enable;
  assign rom_addr   = r_rom_addr;
  assign inst_valid = w_valid;
  assign inst_data  = w_valid ? r_mem_data[r_rd_ptr] : '0;
  assign inst_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : '0;
  assign fifo_count = r_count;

endmodule
